rf_hazard_ctrl: RTL and testbench
=================================

Name: rf_hazard_ctrl

Overview:
Hazard and operand-sourcing controller for the pipelined register file and writeback mux.
- Keeps a shadow record of in-flight destination registers for the EX, MEM and WB stages.
- Decides per instruction in ID whether to stall, whether to insert a bubble, and where each source operand comes from: RF, EX/MEM, MEM/WB, or the same-cycle writeback value.
- Sits beside the ID stage and drives the IF/ID hold, the ID/EX bubble and the EX operand muxes.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rR1  in  REG_AW  source register 1 address.
- id_rR2  in  REG_AW  source register 2 address.
- id_re1  in  1  instruction reads rR1.
- id_re2  in  1  instruction reads rR2.
- id_wR  in  REG_AW  destination register.
- id_we  in  1  instruction writes the RF.
- id_wd_sel  in  2  writeback source: 00 ALU, 01 DRAM, 11 PC+4.
- flush  in  1  taken branch/jump resolved in EX; squash ID and younger.
- stall  out  1  hold PC and IF/ID (combinational).
- bubble  out  1  load NOP into ID/EX; equals stall & ~flush.
- id_byp1  out  1  ID operand 1 takes wD instead of rD1 (combinational).
- id_byp2  out  1  ID operand 2 takes wD instead of rD2 (combinational).
- ex_fwd1  out  2  EX operand 1 source (registered): 00 ID/EX, 01 EX/MEM, 10 MEM/WB.
- ex_fwd2  out  2  EX operand 2 source (registered), same encoding.
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - All shadow entries cleared: EX, MEM, WB each hold {we=0, wR=0, late=0}.
  - ex_fwd1 = ex_fwd2 = 00; stall_cnt = 0.
  - Combinational outputs follow from the cleared state: stall=0, bubble=0, id_byp*=0.
- Hazard match:
  - "match(s,i)" = stage s has we=1, wR_s != 0, wR_s == id_rRi, id_rei=1, id_valid=1.
  - Register 0 never matches.
- Stall, combinational:
  - stall = (match(EX,1) | match(EX,2)) & EX.late & ~flush.
  - late = (wd_sel == 01): the DRAM result is not available until WB.
  - One stall cycle resolves a load-use hazard. The same instruction is re-evaluated next cycle with the load now in MEM, so it forwards from 10.
- Forward selection, computed in ID and registered into ex_fwd* at the posedge when the ID instruction advances (stall=0):
  - match(EX,i) & ~late -> 01.
  - else match(MEM,i) -> 10.
  - else 00.
  - Younger producer wins: EX beats MEM.
  - When a bubble or flush enters EX, ex_fwd* <= 00.
- Same-cycle writeback bypass, combinational:
  - id_bypi = match(WB,i) & ~match(EX,i) & ~match(MEM,i).
  - Needed because the RF writes on the clock edge and ID reads before that edge.
- Shadow pipeline, every posedge:
  - WB <= MEM; MEM <= EX. There are no downstream stalls.
  - EX <= {id_we & id_valid, id_wR, id_wd_sel==01} when stall=0 and flush=0.
  - EX <= cleared when stall=1 or flush=1.
- Flush:
  - flush=1 forces stall=0 and bubble=0; flush has priority over stall.
  - The instruction in ID is discarded: its EX entry is cleared at the next edge.
  - MEM and WB advance normally.
- stall_cnt:
  - Increments on each posedge with stall=1.
  - Saturates at all-ones and does not wrap.
- Reset mid-operation: all state clears immediately; any in-flight stall drops the same cycle.
- id_valid=0: no hazards are raised and a cleared entry enters EX.

Test Plan:
- ALU RAW distance 1: `add x5` then `sub x6,x5,x5` back-to-back -> stall=0; at the sub's EX cycle ex_fwd1=ex_fwd2=01.
- Load-use: `lw x7` then `add x8,x7,x1` -> stall=1 and bubble=1 for exactly 1 cycle; stall_cnt 0->1; the add then enters EX with ex_fwd1=10, ex_fwd2=00.
- Distance 3: `add x9`, nop, nop, `or x10,x9,x0` -> at the or's ID cycle id_byp1=1, id_byp2=0; ex_fwd1=00.
- Priority and x0:
  - `add x3`, then `add x3`, then `use x3` -> ex_fwd1=01, the newer producer.
  - A writer to x0 followed by a reader of x0 -> no stall, no forward, no bypass.
- Flush over stall: `lw x4` in EX with a dependent in ID and flush=1 the same cycle -> stall=0, bubble=0, next EX entry cleared, stall_cnt unchanged.
- Saturation and reset:
  - With STALL_CNT_W=2, 5 load-use stalls -> stall_cnt=3.
  - Assert rst_n=0 during a stall cycle -> stall, stall_cnt and ex_fwd* read 0 immediately.

Source files
------------

// File: rtl/rf_hazard_ctrl.sv
// Hazard and operand-sourcing controller for the pipelined register file.
// Tracks the destination registers of the instructions in EX, MEM and WB.
// From that record it decides, for the instruction in ID, whether to stall,
// whether a bubble goes into ID/EX, and where each source operand comes from.
//
// ID advance rule: the instruction in ID moves to EX at a posedge exactly when
// stall=0. When stall=1, or when flush=1, a cleared entry (bubble) enters EX
// instead. Nothing downstream of EX ever stalls, so MEM and WB always advance.
module rf_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int REG_AW      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rR1,
  input  logic [REG_AW-1:0]      id_rR2,
  input  logic                   id_re1,
  input  logic                   id_re2,
  input  logic [REG_AW-1:0]      id_wR,
  input  logic                   id_we,
  input  logic [1:0]             id_wd_sel,
  input  logic                   flush,
  output logic                   stall,
  output logic                   bubble,
  output logic                   id_byp1,
  output logic                   id_byp2,
  output logic [1:0]             ex_fwd1,
  output logic [1:0]             ex_fwd2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // late=1 marks a DRAM load: its value only exists once it reaches WB.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] wr;
    logic              late;
  } shadow_t;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] WD_DRAM   = 2'b01;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_d;
  logic [1:0] fwd1_q, fwd2_q, fwd1_d, fwd2_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
  logic stall_w;

  // A stage feeds a source operand when it writes that register, the register
  // is not x0, and ID really reads it.
  function automatic logic match(input shadow_t s, input logic [REG_AW-1:0] r,
                                 input logic re, input logic v);
    return v & re & s.we & (s.wr != '0) & (s.wr == r);
  endfunction

  // Hazard detection, bypass and forward-select decisions for the ID instruction.
  always_comb begin
    m_ex1   = match(ex_q,  id_rR1, id_re1, id_valid);
    m_ex2   = match(ex_q,  id_rR2, id_re2, id_valid);
    m_mem1  = match(mem_q, id_rR1, id_re1, id_valid);
    m_mem2  = match(mem_q, id_rR2, id_re2, id_valid);
    m_wb1   = match(wb_q,  id_rR1, id_re1, id_valid);
    m_wb2   = match(wb_q,  id_rR2, id_re2, id_valid);

    // Load-use: the load is one stage ahead and its data is not ready yet.
    stall_w = (m_ex1 | m_ex2) & ex_q.late & ~flush;

    // The RF write happens on the same edge ID reads, so WB needs its own path;
    // younger producers in EX/MEM override it.
    id_byp1 = m_wb1 & ~m_ex1 & ~m_mem1;
    id_byp2 = m_wb2 & ~m_ex2 & ~m_mem2;

    // Younger producer wins: EX beats MEM.
    fwd1_d = FWD_IDEX;
    fwd2_d = FWD_IDEX;
    if (!stall_w && !flush) begin
      if (m_ex1 && !ex_q.late) fwd1_d = FWD_EXMEM;
      else if (m_mem1)         fwd1_d = FWD_MEMWB;
      if (m_ex2 && !ex_q.late) fwd2_d = FWD_EXMEM;
      else if (m_mem2)         fwd2_d = FWD_MEMWB;
    end

    // Entry entering EX: the ID instruction, or a cleared bubble.
    ex_d = '0;
    if (!stall_w && !flush) begin
      ex_d.we   = id_we & id_valid;
      ex_d.wr   = id_wR;
      ex_d.late = (id_wd_sel == WD_DRAM);
    end

    // Saturating stall-cycle count.
    cnt_d = cnt_q;
    if (stall_w && (cnt_q != '1)) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  // Shadow pipeline, registered forward selects and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fwd1_q <= FWD_IDEX;
      fwd2_q <= FWD_IDEX;
      cnt_q  <= '0;
    end else begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall     = stall_w;
  assign bubble    = stall_w & ~flush;
  assign ex_fwd1   = fwd1_q;
  assign ex_fwd2   = fwd2_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Bench for rf_hazard_ctrl: directed pipeline scenarios followed by random
// instruction streams, checked against a history-of-issued-instructions model.
// A second instance with a 2-bit stall counter shares all inputs.
module tb_rf_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_re1, id_re2, id_we, flush;
  logic [4:0] id_rR1, id_rR2, id_wR;
  logic [1:0] id_wd_sel;

  logic        stall, bubble, id_byp1, id_byp2;
  logic [1:0]  ex_fwd1, ex_fwd2;
  logic [15:0] stall_cnt;

  logic        stall_s, bubble_s, id_byp1_s, id_byp2_s;
  logic [1:0]  ex_fwd1_s, ex_fwd2_s;
  logic [1:0]  stall_cnt_s;

  rf_hazard_ctrl #(.STALL_CNT_W(16), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_re1(id_re1), .id_re2(id_re2), .id_wR(id_wR), .id_we(id_we), .id_wd_sel(id_wd_sel),
    .flush(flush), .stall(stall), .bubble(bubble), .id_byp1(id_byp1), .id_byp2(id_byp2),
    .ex_fwd1(ex_fwd1), .ex_fwd2(ex_fwd2), .stall_cnt(stall_cnt)
  );

  rf_hazard_ctrl #(.STALL_CNT_W(2), .REG_AW(5)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
    .id_re1(id_re1), .id_re2(id_re2), .id_wR(id_wR), .id_we(id_we), .id_wd_sel(id_wd_sel),
    .flush(flush), .stall(stall_s), .bubble(bubble_s), .id_byp1(id_byp1_s), .id_byp2(id_byp2_s),
    .ex_fwd1(ex_fwd1_s), .ex_fwd2(ex_fwd2_s), .stall_cnt(stall_cnt_s)
  );

  // ---------------- scoreboard / reference model ----------------
  // hist[0] is the most recently issued slot (in EX), hist[1] the one before
  // (MEM), hist[2] the one before that (WB). Bubbles are recorded as non-writers.
  typedef struct {
    bit     we;
    int     wr;
    bit     late;
  } rec_t;

  rec_t hist[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt, exp_cnt_s;
  int   exp_f1, exp_f2;
  logic last_stall, last_bubble, last_byp1, last_byp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t z;
    z.we = 0; z.wr = 0; z.late = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(z);
    exp_cnt = 0; exp_cnt_s = 0; exp_f1 = 0; exp_f2 = 0;
  endtask

  // Age (0=EX, 1=MEM, 2=WB) of the youngest in-flight producer of r, 3 if none.
  function automatic int src_age(input logic v, input logic [4:0] r, input logic re);
    if (!v || !re || r == 5'd0) return 3;
    for (int a = 0; a < 3; a++)
      if (hist[a].we && hist[a].wr == int'(r)) return a;
    return 3;
  endfunction

  // ---------------- driver ----------------
  // One pipeline cycle: drive ID at the falling edge, check the combinational
  // decisions, let the rising edge happen, then check the registered outputs.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic e1,
                     input logic [4:0] r2, input logic e2, input logic [4:0] wr,
                     input logic we, input logic [1:0] sel, input logic fl);
    int   s1, s2;
    logic es;
    rec_t nr;
    @(negedge clk);
    id_valid = v; id_rR1 = r1; id_re1 = e1; id_rR2 = r2; id_re2 = e2;
    id_wR = wr; id_we = we; id_wd_sel = sel; flush = fl;
    #1;
    s1 = src_age(v, r1, e1);
    s2 = src_age(v, r2, e2);
    es = ((s1 == 0) || (s2 == 0)) && hist[0].late && !fl;
    chk("stall",   stall,   es);
    chk("bubble",  bubble,  es);
    chk("id_byp1", id_byp1, s1 == 2);
    chk("id_byp2", id_byp2, s2 == 2);
    last_stall = stall; last_bubble = bubble; last_byp1 = id_byp1; last_byp2 = id_byp2;
    if (es || fl) begin
      nr.we = 0; nr.wr = 0; nr.late = 0;
      exp_f1 = 0; exp_f2 = 0;
    end else begin
      nr.we = we & v; nr.wr = int'(wr); nr.late = (sel == 2'b01);
      exp_f1 = (s1 == 0) ? 1 : (s1 == 1) ? 2 : 0;
      exp_f2 = (s2 == 0) ? 1 : (s2 == 1) ? 2 : 0;
    end
    if (es) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt_s < 3) exp_cnt_s++;
    end
    @(posedge clk);
    hist.push_front(nr);
    void'(hist.pop_back());
    #1;
    chk("ex_fwd1",     ex_fwd1,     exp_f1);
    chk("ex_fwd2",     ex_fwd2,     exp_f2);
    chk("stall_cnt",   stall_cnt,   exp_cnt);
    chk("stall_cnt_s", stall_cnt_s, exp_cnt_s);
  endtask

  task automatic nop();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_valid = 0; id_rR1 = 0; id_rR2 = 0; id_re1 = 0; id_re2 = 0;
    id_wR = 0; id_we = 0; id_wd_sel = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_stall",   stall,       0);
    chk("rst_bubble",  bubble,      0);
    chk("rst_fwd1",    ex_fwd1,     0);
    chk("rst_fwd2",    ex_fwd2,     0);
    chk("rst_cnt",     stall_cnt,   0);
    chk("rst_cnt_s",   stall_cnt_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] sel_tab [3];
    logic       hv, he1, he2, hwe;
    logic [4:0] hr1, hr2, hwr;
    logic [1:0] hsel;
    sel_tab[0] = 2'b00; sel_tab[1] = 2'b01; sel_tab[2] = 2'b11;
    rst_n = 1'b0;
    model_reset();
    do_reset();

    // Five load-use stalls: the 2-bit counter must stop at 3.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 2'b01, 0);   // lw x7
      cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 2'b00, 0);   // add x8,x7,x1 (stalls)
      chk("sat_stall", last_stall, 1);
      cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 2'b00, 0);   // add re-evaluated
    end
    chk("sat_cnt_s", stall_cnt_s, 3);
    chk("sat_cnt",   stall_cnt,   5);
    nop(); nop(); nop();

    // ALU RAW distance 1.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'b00, 0);     // add x5
    cyc(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 2'b00, 0);     // sub x6,x5,x5
    chk("raw1_stall", last_stall, 0);
    chk("raw1_fwd1",  ex_fwd1, 2'b01);
    chk("raw1_fwd2",  ex_fwd2, 2'b01);
    nop(); nop(); nop();

    // Load-use, single instance.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 2'b01, 0);     // lw x7
    cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 2'b00, 0);     // add x8,x7,x1
    chk("lu_stall",  last_stall,  1);
    chk("lu_bubble", last_bubble, 1);
    chk("lu_cnt",    stall_cnt,   6);
    chk("lu_bub_fwd1", ex_fwd1, 2'b00);
    cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 2'b00, 0);
    chk("lu_stall2", last_stall, 0);
    chk("lu_fwd1",   ex_fwd1, 2'b10);
    chk("lu_fwd2",   ex_fwd2, 2'b00);
    nop(); nop(); nop();

    // Distance 3: WB bypass.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 2'b00, 0);     // add x9
    nop(); nop();
    cyc(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, 2'b00, 0);    // or x10,x9,x0
    chk("d3_byp1", last_byp1, 1);
    chk("d3_byp2", last_byp2, 0);
    chk("d3_fwd1", ex_fwd1, 2'b00);
    nop(); nop(); nop();

    // Younger producer wins.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00, 0);
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'b00, 0);
    cyc(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 2'b00, 0);
    chk("prio_fwd1", ex_fwd1, 2'b01);
    nop(); nop(); nop();

    // x0 never matches.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 2'b01, 0);     // lw x0
    cyc(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 2'b00, 0);
    chk("x0_stall", last_stall, 0);
    chk("x0_byp1",  last_byp1,  0);
    chk("x0_fwd1",  ex_fwd1, 2'b00);
    chk("x0_fwd2",  ex_fwd2, 2'b00);
    nop(); nop(); nop();

    // Flush beats stall; the flushed writer of x5 must not be forwarded.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 2'b01, 0);     // lw x4
    cyc(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 2'b00, 1);     // dependent, flushed
    chk("fl_stall",  last_stall,  0);
    chk("fl_bubble", last_bubble, 0);
    chk("fl_cnt",    stall_cnt,   6);
    cyc(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 2'b00, 0);
    chk("fl_clear_fwd1", ex_fwd1, 2'b00);
    nop(); nop(); nop();

    // Random instruction streams; a stalled instruction is held in ID.
    hv = 0; he1 = 0; he2 = 0; hwe = 0; hr1 = 0; hr2 = 0; hwr = 0; hsel = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        hv   = ($urandom_range(0, 7) != 0);
        hr1  = 5'($urandom_range(0, 3));
        hr2  = 5'($urandom_range(0, 3));
        he1  = 1'($urandom_range(0, 1));
        he2  = 1'($urandom_range(0, 1));
        hwr  = 5'($urandom_range(0, 3));
        hwe  = ($urandom_range(0, 3) != 0);
        hsel = sel_tab[$urandom_range(0, 2)];
      end
      cyc(hv, hr1, he1, hr2, he2, hwr, hwe, hsel, $urandom_range(0, 7) == 0);
    end

    // Reset asserted in the middle of a stall cycle.
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd2, 1, 2'b00, 0);     // add x2
    cyc(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 2'b01, 0);     // lw x7 (forwards x2)
    chk("pre_rst_fwd1", ex_fwd1, 2'b01);
    @(negedge clk);
    id_valid = 1; id_rR1 = 5'd7; id_re1 = 1; id_rR2 = 5'd0; id_re2 = 0;
    id_wR = 5'd8; id_we = 1; id_wd_sel = 2'b00; flush = 0;
    #1;
    chk("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall",  stall,     0);
    chk("mid_rst_bubble", bubble,    0);
    chk("mid_rst_cnt",    stall_cnt, 0);
    chk("mid_rst_fwd1",   ex_fwd1,   0);
    chk("mid_rst_fwd2",   ex_fwd2,   0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 2'b00, 0);
    chk("post_rst_stall", last_stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

endmodule
